// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// Module : id_ex_stage_pkg
// Desc   : Shared CPU definitions: ALU command codes, forwarding select codes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int IMM_W      = 16;
  localparam int ALU_CMD_W  = 3;
  localparam int FWD_SEL_W  = 2;

  typedef enum logic [ALU_CMD_W-1:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_OR   = 3'd7
  } alu_cmd_e;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Register 0 is hard-wired to zero, so it is never a forwarding hit.
  function automatic logic fwd_hit(input logic                  wr_en,
                                   input logic [REG_ADDR_W-1:0] wr_rd,
                                   input logic [REG_ADDR_W-1:0] src);
    return wr_en && (wr_rd == src) && (src != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_forward_select.sv
// ============================================================================
// Module : forward_select
// Desc   : Picks the forwarding source for one operand; EX/MEM beats MEM/WB.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_select
  import id_ex_stage_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  output fwd_sel_e              sel
);

  always_comb begin
    sel = FWD_NONE;
    if (fwd_hit(exmem_reg_write, exmem_rd, src_addr)) begin
      sel = FWD_EXMEM;
    end else if (fwd_hit(memwb_reg_write, memwb_rd, src_addr)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module : id_ex_stage
// Desc   : ID/EX pipeline register with operand forwarding and immediate extend.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      rs_data,
  input  logic [WIDTH-1:0]      rt_data,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic [IMM_W-1:0]      imm16,
  input  logic                  alu_src,
  input  logic                  sign_ext,
  input  logic [ALU_CMD_W-1:0]  alu_cmd_in,
  input  logic                  reg_write_in,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [WIDTH-1:0]      exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [WIDTH-1:0]      memwb_result,
  output logic [WIDTH-1:0]      operandA,
  output logic [WIDTH-1:0]      operandB,
  output logic [ALU_CMD_W-1:0]  command,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic                  reg_write_out,
  output logic [WIDTH-1:0]      store_data
);

  fwd_sel_e         sel_a;
  fwd_sel_e         sel_b;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] ext_imm;
  logic [WIDTH-1:0] op_b_next;

  forward_select u_fwd_rs (
    .src_addr        (rs_addr),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (sel_a)
  );

  forward_select u_fwd_rt (
    .src_addr        (rt_addr),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (sel_b)
  );

  always_comb begin
    fwd_a = rs_data;
    case (sel_a)
      FWD_EXMEM: fwd_a = exmem_result;
      FWD_MEMWB: fwd_a = memwb_result;
      default:   fwd_a = rs_data;
    endcase
  end

  always_comb begin
    fwd_b = rt_data;
    case (sel_b)
      FWD_EXMEM: fwd_b = exmem_result;
      FWD_MEMWB: fwd_b = memwb_result;
      default:   fwd_b = rt_data;
    endcase
  end

  assign ext_imm   = sign_ext ? {{(WIDTH-IMM_W){imm16[IMM_W-1]}}, imm16}
                              : {{(WIDTH-IMM_W){1'b0}}, imm16};
  assign op_b_next = alu_src ? ext_imm : fwd_b;

  // Flush outranks stall so a squashed slot can never be held in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operandA      <= '0;
      operandB      <= '0;
      command       <= ALU_ADD;
      out_valid     <= 1'b0;
      rd_addr_out   <= '0;
      reg_write_out <= 1'b0;
      store_data    <= '0;
    end else if (flush) begin
      operandA      <= '0;
      operandB      <= '0;
      command       <= ALU_ADD;
      out_valid     <= 1'b0;
      rd_addr_out   <= '0;
      reg_write_out <= 1'b0;
      store_data    <= '0;
    end else if (!stall) begin
      operandA      <= fwd_a;
      operandB      <= op_b_next;
      command       <= alu_cmd_in;
      out_valid     <= in_valid;
      rd_addr_out   <= rd_addr_in;
      reg_write_out <= reg_write_in & in_valid;
      store_data    <= fwd_b;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module : tb_id_ex_stage
// Desc   : Directed self-checking bench for id_ex_stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr_in = '0;
  logic [15:0] imm16 = '0;
  logic        alu_src = 1'b0, sign_ext = 1'b0;
  logic [2:0]  alu_cmd_in = '0;
  logic        reg_write_in = 1'b0;
  logic        exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic [31:0] exmem_result = '0, memwb_result = '0;
  logic [31:0] operandA, operandB, store_data;
  logic [2:0]  command;
  logic        out_valid, reg_write_out;
  logic [4:0]  rd_addr_out;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr_in(rd_addr_in), .imm16(imm16), .alu_src(alu_src), .sign_ext(sign_ext),
    .alu_cmd_in(alu_cmd_in), .reg_write_in(reg_write_in),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .operandA(operandA), .operandB(operandB), .command(command),
    .out_valid(out_valid), .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out),
    .store_data(store_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".A"},   operandA, 32'h0);
    check({tag, ".B"},   operandB, 32'h0);
    check({tag, ".cmd"}, {29'd0, command}, 32'd0);
    check({tag, ".vld"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".rd"},  {27'd0, rd_addr_out}, 32'd0);
    check({tag, ".rw"},  {31'd0, reg_write_out}, 32'd0);
    check({tag, ".st"},  store_data, 32'h0);
  endtask

  logic [32:0] alu_sum;
  logic        alu_ovf;

  initial begin
    // Asynchronous reset asserted mid-cycle, away from any edge
    #3 reset = 1'b1;
    #1 check_bubble("reset_async");

    // Release reset while stalled with a valid slot: bubble must survive
    stall = 1'b1; in_valid = 1'b1; reg_write_in = 1'b1;
    rs_addr = 5'd3; rs_data = 32'd5; rd_addr_in = 5'd9; alu_cmd_in = 3'd2;
    tick();
    reset = 1'b0;
    tick();
    check_bubble("reset_stall");

    // Plain load, no forwarding
    stall = 1'b0;
    rs_addr = 5'd3; rt_addr = 5'd4; rs_data = 32'd5; rt_data = 32'd7;
    alu_cmd_in = 3'd1; rd_addr_in = 5'd9;
    tick();
    check("plain.A",   operandA, 32'd5);
    check("plain.B",   operandB, 32'd7);
    check("plain.cmd", {29'd0, command}, 32'd1);
    check("plain.vld", {31'd0, out_valid}, 32'd1);
    check("plain.rd",  {27'd0, rd_addr_out}, 32'd9);
    check("plain.rw",  {31'd0, reg_write_out}, 32'd1);
    check("plain.st",  store_data, 32'd7);

    // No combinational path: input change between edges is invisible
    rs_data = 32'hDEAD_BEEF;
    #2 check("nocomb.A", operandA, 32'd5);

    // Double hazard on rs and rt: EX/MEM wins
    rs_addr = 5'd8; rt_addr = 5'd8; rs_data = 32'h99; rt_data = 32'h98;
    exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_result = 32'h22;
    tick();
    check("fwd_both.A",  operandA, 32'h11);
    check("fwd_both.B",  operandB, 32'h11);
    check("fwd_both.st", store_data, 32'h11);

    exmem_reg_write = 1'b0;
    tick();
    check("fwd_memwb.A",  operandA, 32'h22);
    check("fwd_memwb.st", store_data, 32'h22);

    // Register 0 is never forwarded
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    rs_addr = 5'd0; rt_addr = 5'd0; rs_data = 32'h55; rt_data = 32'h66;
    tick();
    check("r0.A",  operandA, 32'h55);
    check("r0.st", store_data, 32'h66);

    // Immediate: sign and zero extension, store_data tracks rt
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    rt_addr = 5'd4; rt_data = 32'd7;
    imm16 = 16'hFFFC; alu_src = 1'b1; sign_ext = 1'b1;
    tick();
    check("imm_sx.B",  operandB, 32'hFFFF_FFFC);
    check("imm_sx.st", store_data, 32'd7);

    sign_ext = 1'b0; in_valid = 1'b0;
    tick();
    check("imm_zx.B",   operandB, 32'h0000_FFFC);
    check("imm_zx.st",  store_data, 32'd7);
    check("invalid.vld", {31'd0, out_valid}, 32'd0);
    check("invalid.rw",  {31'd0, reg_write_out}, 32'd0);

    // Load OR with A=1, then stall three edges with changing inputs
    in_valid = 1'b1; alu_src = 1'b0; alu_cmd_in = 3'd7;
    rs_addr = 5'd2; rs_data = 32'd1; rd_addr_in = 5'd12;
    tick();
    check("or.A",   operandA, 32'd1);
    check("or.cmd", {29'd0, command}, 32'd7);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rs_data = 32'h100 + i; alu_cmd_in = 3'(i); rd_addr_in = 5'(20 + i);
      tick();
      check("stall.A",   operandA, 32'd1);
      check("stall.cmd", {29'd0, command}, 32'd7);
      check("stall.rd",  {27'd0, rd_addr_out}, 32'd12);
      check("stall.vld", {31'd0, out_valid}, 32'd1);
    end

    flush = 1'b1;
    tick();
    check_bubble("flush");

    // End-to-end with a reference ALU on the registered outputs
    flush = 1'b0; stall = 1'b0;
    rs_addr = 5'd5; rs_data = 32'h7FFF_FFFF;
    imm16 = 16'h0001; sign_ext = 1'b1; alu_src = 1'b1; alu_cmd_in = 3'd0;
    tick();
    alu_sum = {1'b0, operandA} + {1'b0, operandB};
    alu_ovf = (operandA[31] == operandB[31]) && (alu_sum[31] != operandA[31]);
    check("alu.result", alu_sum[31:0], 32'h8000_0000);
    check("alu.ovf",    {31'd0, alu_ovf}, 32'd1);
    check("alu.carry",  {31'd0, alu_sum[32]}, 32'd0);

    // Asynchronous reset again from a loaded state
    #2 reset = 1'b1;
    #1 check_bubble("reset_again");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width of operands and results.
REQ-002 Port clk input 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset input 1: asynchronous, active-high reset.
REQ-004 Ports in_valid input 1, stall input 1, flush input 1: decode-slot valid, hold stage, squash stage.
REQ-005 Ports rs_data, rt_data input WIDTH: register-file read data.
REQ-006 Ports rs_addr, rt_addr, rd_addr_in input 5: source and destination register numbers.
REQ-007 Ports imm16 input 16, alu_src input 1 (1 = immediate as B), sign_ext input 1 (1 = sign-extend, 0 = zero-extend).
REQ-008 Ports alu_cmd_in input 3, reg_write_in input 1: ALU command (ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7), write-back enable.
REQ-009 Ports exmem_reg_write input 1, exmem_rd input 5, exmem_result input WIDTH: forwarding source 1.
REQ-010 Ports memwb_reg_write input 1, memwb_rd input 5, memwb_result input WIDTH: forwarding source 2.
REQ-011 Ports operandA, operandB output WIDTH, command output 3: registered, wired directly to the ALU operandA/operandB/command.
REQ-012 Ports out_valid output 1, rd_addr_out output 5, reg_write_out output 1, store_data output WIDTH: registered sideband.

Function
REQ-013 Forwarded A SHALL be exmem_result if exmem_reg_write and exmem_rd==rs_addr and rs_addr!=0; else memwb_result if memwb_reg_write and memwb_rd==rs_addr and rs_addr!=0; else rs_data.
REQ-014 Forwarded rt value SHALL follow the same priority using rt_addr; EX/MEM SHALL win when both sources match.
REQ-015 Register 0 SHALL never be forwarded; a source address of 0 SHALL pass rs_data/rt_data unchanged.
REQ-016 Extended immediate SHALL be {16{imm16[15]},imm16} when sign_ext=1, {16'b0,imm16} when sign_ext=0.
REQ-017 operandB SHALL capture extended immediate when alu_src=1, forwarded rt otherwise; store_data SHALL always capture forwarded rt.
REQ-018 Latency SHALL be exactly one clock: inputs sampled at edge N appear on outputs after edge N.
REQ-019 Priority per edge SHALL be flush > stall > load.
REQ-020 flush=1 SHALL load a bubble: out_valid=0, reg_write_out=0, command=ADD, operandA=operandB=store_data=0, rd_addr_out=0, regardless of stall.
REQ-021 stall=1 with flush=0 SHALL hold every output register unchanged.
REQ-022 Otherwise the stage SHALL load forwarded/extended data, alu_cmd_in, rd_addr_in, out_valid=in_valid, reg_write_out=reg_write_in&in_valid.
REQ-023 in_valid=0 with load SHALL produce reg_write_out=0 but MAY load data fields.
REQ-024 No combinational path SHALL exist from any input to any output.

Reset
REQ-025 reset=1 SHALL immediately, without a clock, force all outputs to the bubble values of REQ-020.
REQ-026 reset deassertion mid-stall SHALL leave the bubble in place until the first non-stalled edge.

Structure
REQ-027 ALU command codes (ADD..OR) and the 2-bit forwarding select codes (NONE, EXMEM, MEMWB) SHALL live in the shared CPU package also used by the ALU and control.
REQ-028 Forwarding selection SHALL be one sub-module, forward_select, instantiated twice (rs, rt).

Verification
REQ-029 Reset then idle: reset=1 mid-cycle -> outputs zero, command=0 at once, out_valid=0.
REQ-030 rs=3 rt=4 rs_data=5 rt_data=7 cmd=SUB, no forwarding, one edge -> operandA=5 operandB=7 command=1 out_valid=1.
REQ-031 Double hazard: rs=8, exmem_rd=8 result=0x11, memwb_rd=8 result=0x22, both write -> operandA=0x11; exmem_reg_write=0 -> 0x22; rs=0 with exmem_rd=0 -> rs_data.
REQ-032 Immediate: imm16=0xFFFC alu_src=1 sign_ext=1 -> operandB=0xFFFFFFFC; sign_ext=0 -> 0x0000FFFC; store_data=forwarded rt both times.
REQ-033 Stall/flush: load cmd=OR A=1, then stall=1 with new inputs for 3 edges -> outputs unchanged; stall=1 flush=1 -> bubble, reg_write_out=0.
REQ-034 End-to-end with ALU: A=0x7FFFFFFF, imm=1 sign_ext=1 ADD -> ALU result 0x80000000, overflow=1, carryout=0 one cycle later.
